// File: rtl/pwm_bank_pkg.sv
// Shared register map, CTRL field positions and counter states for the PWM bank.
package pwm_bank_pkg;

  localparam int unsigned OFF_CTRL     = 32'h00;
  localparam int unsigned OFF_PRESCALE = 32'h04;
  localparam int unsigned OFF_PERIOD   = 32'h08;
  localparam int unsigned OFF_STATUS   = 32'h0C;
  localparam int unsigned OFF_DUTY     = 32'h10;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_CENTER = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  typedef enum logic [1:0] {IDLE, UP, DOWN} cnt_state_t;

endpackage

// File: rtl/pwm_bank_mmio_timebase.sv
// Shared PWM time base: prescaler plus edge/center period counter producing cnt and a
// one-clock boundary pulse at the end of each PWM period.
module pwm_timebase
  import pwm_bank_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int PRE_W = 16
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             en_i,
  input  logic             center_i,
  input  logic [PRE_W-1:0] prescale_i,
  input  logic [CNT_W-1:0] period_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             run_o,
  output logic             start_o,
  output logic             boundary_o
);

  cnt_state_t       state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  // >= rather than == so a PRESCALE lowered mid-count still wraps immediately
  assign tick = (pre_q >= prescale_i);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    boundary_o = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
      pre_d   = '0;
      cnt_d   = '0;
    end else begin
      if (state_q != IDLE) pre_d = tick ? '0 : pre_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          state_d = UP;
          pre_d   = '0;
          cnt_d   = '0;
        end
        UP: if (tick) begin
          if (cnt_q >= period_i) begin
            if (center_i) begin
              state_d = DOWN;
              cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
            end else begin
              cnt_d      = '0;
              boundary_o = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DOWN: if (tick) begin
          if (cnt_q == '0) begin
            // Resume at 1 so the trough value 0 is not repeated: period = 2*PERIOD ticks
            state_d    = UP;
            cnt_d      = (period_i == '0) ? '0 : CNT_W'(1);
            boundary_o = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cnt_o   = cnt_q;
  assign run_o   = (state_q != IDLE);
  assign start_o = (state_q == IDLE) & en_i;

endmodule

// File: rtl/pwm_bank_mmio.sv
// Memory-mapped PWM bank: register file, shadow registers reloaded at period boundaries,
// per-channel duty comparators and the wrap interrupt.
module pwm_bank_mmio
  import pwm_bank_pkg::*;
#(
  parameter int NCH    = 8,
  parameter int CNT_W  = 16,
  parameter int PRE_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [NCH-1:0]    pwm_out,
  output logic              irq
);

  localparam int WI_W = ADDR_W - 2;
  localparam logic [WI_W-1:0] W_CTRL     = WI_W'(OFF_CTRL / 4);
  localparam logic [WI_W-1:0] W_PRESCALE = WI_W'(OFF_PRESCALE / 4);
  localparam logic [WI_W-1:0] W_PERIOD   = WI_W'(OFF_PERIOD / 4);
  localparam logic [WI_W-1:0] W_STATUS   = WI_W'(OFF_STATUS / 4);
  localparam logic [WI_W-1:0] W_DUTY     = WI_W'(OFF_DUTY / 4);

  logic [WI_W-1:0]             widx;
  logic                        wr;
  logic [2:0]                  ctrl_q, ctrl_d;
  logic [PRE_W-1:0]            prescale_q, prescale_d;
  logic [CNT_W-1:0]            period_q, period_d, period_sh_q, period_sh_d;
  logic [NCH-1:0][CNT_W-1:0]   duty_q, duty_d, duty_sh_q, duty_sh_d;
  logic                        center_sh_q, center_sh_d;
  logic                        wrap_q, wrap_d;
  logic [NCH-1:0]              pwm_d;
  logic [CNT_W-1:0]            cnt;
  logic                        run, start, boundary;
  logic                        unused_bits;

  assign widx        = addr[ADDR_W-1:2];
  assign wr          = sel & we;
  assign unused_bits = ^{addr[1:0], wdata};

  pwm_timebase #(
    .CNT_W (CNT_W),
    .PRE_W (PRE_W)
  ) u_tb (
    .gclk       (clk),
    .grst_n     (reset_n),
    .en_i       (ctrl_q[CTRL_EN]),
    .center_i   (center_sh_q),
    .prescale_i (prescale_q),
    .period_i   (period_sh_q),
    .cnt_o      (cnt),
    .run_o      (run),
    .start_o    (start),
    .boundary_o (boundary)
  );

  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    period_d   = period_q;
    duty_d     = duty_q;
    wrap_d     = wrap_q;
    if (wr) begin
      if (widx == W_CTRL)                wrap_d = wrap_q;
      if (widx == W_CTRL)                ctrl_d     = wdata[2:0];
      if (widx == W_PRESCALE)            prescale_d = wdata[PRE_W-1:0];
      if (widx == W_PERIOD)              period_d   = wdata[CNT_W-1:0];
      if (widx == W_STATUS && wdata[0])  wrap_d     = 1'b0;
      for (int i = 0; i < NCH; i++)
        if (widx == W_DUTY + WI_W'(i))   duty_d[i]  = wdata[CNT_W-1:0];
    end
    // A boundary in the same clock as a W1C keeps the flag set
    if (boundary) wrap_d = 1'b1;
  end

  always_comb begin
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    center_sh_d = center_sh_q;
    if (start || boundary) begin
      period_sh_d = period_q;
      duty_sh_d   = duty_q;
      center_sh_d = ctrl_q[CTRL_CENTER];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cmp
    assign pwm_d[g] = run & ctrl_q[CTRL_EN] & (cnt < duty_sh_q[g]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q      <= '0;
      prescale_q  <= '0;
      period_q    <= '0;
      duty_q      <= '0;
      wrap_q      <= 1'b0;
      period_sh_q <= '0;
      duty_sh_q   <= '0;
      center_sh_q <= 1'b0;
      pwm_out     <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      prescale_q  <= prescale_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      wrap_q      <= wrap_d;
      period_sh_q <= period_sh_d;
      duty_sh_q   <= duty_sh_d;
      center_sh_q <= center_sh_d;
      pwm_out     <= pwm_d;
    end
  end

  assign irq = wrap_q & ctrl_q[CTRL_IRQ_EN];

  always_comb begin
    rdata = '0;
    if (widx == W_CTRL)     rdata = {29'b0, ctrl_q};
    if (widx == W_PRESCALE) rdata = 32'(prescale_q);
    if (widx == W_PERIOD)   rdata = 32'(period_q);
    if (widx == W_STATUS)   rdata = {31'b0, wrap_q};
    for (int i = 0; i < NCH; i++)
      if (widx == W_DUTY + WI_W'(i)) rdata = 32'(duty_q[i]);
  end

endmodule

// File: tb/tb_pwm_bank_mmio.sv
// Scoreboard bench for pwm_bank_mmio: expected register reads and per-clock PWM/STATUS
// values are derived from the period/duty timing model and queued before being compared.
module tb_pwm_bank_mmio;
  localparam int NCH = 8, CNT_W = 16, PRE_W = 16, ADDR_W = 8;
  localparam logic [7:0] A_CTRL = 8'h00, A_PRE = 8'h04, A_PER = 8'h08, A_STAT = 8'h0C;

  logic clk = 1'b0, reset_n = 1'b0, sel = 1'b0, we = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic [NCH-1:0] pwm_out;
  logic irq;

  int n_tests = 0, n_fail = 0;
  logic [31:0]    exp_q[$];
  logic [7:0]     ra_q[$];
  logic [NCH-1:0] pq[$];
  int duty_a[NCH], duty_b[NCH];

  pwm_bank_mmio #(.NCH(NCH), .CNT_W(CNT_W), .PRE_W(PRE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .pwm_out(pwm_out), .irq(irq));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk); sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk); sel = 1'b1; we = 1'b0; addr = a;
    #1 d = rdata; sel = 1'b0;
  endtask

  // Stop, clear wrap, then program PRESCALE, PERIOD and DUTY[*] from duty_a
  task automatic setup(input int pre, input int per);
    bus_write(A_CTRL, 32'h0);
    bus_write(A_STAT, 32'h1);
    bus_write(A_PRE, 32'(pre));
    bus_write(A_PER, 32'(per));
    for (int i = 0; i < NCH; i++) bus_write(8'(16 + 4 * i), 32'(duty_a[i]));
  endtask

  // Negedge j sits after the (j+1)-th edge following the enabling write; the first
  // edge leaves IDLE with cnt=0, pwm_out lags cnt by one clock.
  function automatic logic [NCH-1:0] model_pwm(int j, bit center, int per, int pre);
    logic [NCH-1:0] r;
    int t, c, q, u;
    r = '0;
    if (j < 1) return r;
    t = (j - 1) / (pre + 1);
    if (!center) begin
      c = t % (per + 1);
      q = t / (per + 1);
    end else if (per == 0) begin
      c = 0;
      q = (t + 1) / 2;
    end else begin
      u = t % (2 * per);
      c = (u <= per) ? u : 2 * per - u;
      q = (t <= 2 * per) ? 0 : (t - 1) / (2 * per);
    end
    for (int i = 0; i < NCH; i++) r[i] = (c < ((q == 0) ? duty_a[i] : duty_b[i]));
    return r;
  endfunction

  function automatic int first_wrap(bit center, int per, int pre);
    return (center ? 2 * per + 1 : per + 1) * (pre + 1);
  endfunction

  task automatic test_reset();
    logic [31:0] d, e;
    reset_n = 1'b0;
    bus_write(A_CTRL, 32'h7);
    bus_write(A_PER, 32'h5);
    bus_write(8'h10, 32'h3);
    for (int pass = 0; pass < 2; pass++) begin
      for (int a = 0; a < 'h30; a += 4) exp_q.push_back(32'h0);
      for (int a = 0; a < 'h30; a += 4) begin
        bus_read(8'(a), d);
        e = exp_q.pop_front();
        n_tests++;
        if (d !== e) begin
          n_fail++; $display("FAIL reset_read pass=%0d addr=%h got=%h exp=%h", pass, a, d, e);
        end
      end
      n_tests++;
      if (pwm_out !== '0 || irq !== 1'b0) begin
        n_fail++; $display("FAIL reset_outputs pass=%0d pwm=%b irq=%b exp 0/0", pass, pwm_out, irq);
      end
      if (pass == 0) begin @(negedge clk); reset_n = 1'b1; end
    end
  endtask

  task automatic test_regs();
    logic [31:0] d, e;
    logic [7:0] a;
    bus_write(A_PRE, 32'hABCD_1234);  ra_q.push_back(A_PRE);  exp_q.push_back(32'h1234);
    bus_write(8'h0B, 32'h0000_0007);  ra_q.push_back(A_PER);  exp_q.push_back(32'h7);
    bus_write(A_CTRL, 32'hFFFF_FFFA); ra_q.push_back(A_CTRL); exp_q.push_back(32'h2);
    bus_write(A_STAT, 32'h1);         ra_q.push_back(A_STAT); exp_q.push_back(32'h0);
    for (int i = 0; i < NCH; i++) begin
      bus_write(8'(16 + 4 * i), 32'h0001_0000 | 32'(i * 3 + 1));
      ra_q.push_back(8'(16 + 4 * i)); exp_q.push_back(32'(i * 3 + 1));
    end
    bus_write(8'(16 + 4 * NCH), 32'hFFFF);
    ra_q.push_back(8'(16 + 4 * NCH)); exp_q.push_back(32'h0);
    ra_q.push_back(8'h3C);            exp_q.push_back(32'h0);
    ra_q.push_back(8'h0A);            exp_q.push_back(32'h7);
    ra_q.push_back(8'(12 + 4 * NCH)); exp_q.push_back(32'(3 * NCH - 2));
    while (ra_q.size() > 0) begin
      a = ra_q.pop_front();
      e = exp_q.pop_front();
      bus_read(a, d);
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL reg_readback addr=%h got=%h exp=%h", a, d, e); end
    end
  endtask

  task automatic test_edge();
    logic [NCH-1:0] ep;
    logic [31:0] ew;
    int fw;
    duty_a = '{3, 5, 9, 10, 0, 1, 0, 0};
    duty_b = duty_a;
    setup(0, 9);
    fw = first_wrap(1'b0, 9, 0);
    for (int j = 0; j < 30; j++) begin
      pq.push_back(model_pwm(j, 1'b0, 9, 0));
      exp_q.push_back({31'b0, j >= fw});
    end
    bus_write(A_CTRL, 32'h1);
    sel = 1'b1; we = 1'b0; addr = A_STAT;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      ep = pq.pop_front();
      ew = exp_q.pop_front();
      n_tests++;
      if (pwm_out !== ep) begin n_fail++; $display("FAIL edge_pwm j=%0d got=%b exp=%b", j, pwm_out, ep); end
      n_tests++;
      if (rdata !== ew || irq !== 1'b0) begin
        n_fail++; $display("FAIL edge_wrap j=%0d status=%h irq=%b exp status=%h irq=0", j, rdata, irq, ew);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_double_buffer();
    logic [NCH-1:0] ep;
    duty_a = '{3, 0, 0, 0, 0, 0, 0, 0};
    duty_b = '{7, 0, 0, 0, 0, 0, 0, 0};
    setup(0, 9);
    for (int j = 0; j < 35; j++) pq.push_back(model_pwm(j, 1'b0, 9, 0));
    bus_write(A_CTRL, 32'h1);
    for (int j = 0; j < 35; j++) begin
      @(negedge clk);
      ep = pq.pop_front();
      n_tests++;
      if (pwm_out !== ep) begin n_fail++; $display("FAIL dbuf_pwm j=%0d got=%b exp=%b", j, pwm_out, ep); end
      // DUTY0 rewritten while cnt is mid-period
      if (j == 5) begin sel = 1'b1; we = 1'b1; addr = 8'h10; wdata = 32'd7; end
      if (j == 6) begin sel = 1'b0; we = 1'b0; end
    end
  endtask

  task automatic test_center();
    logic [NCH-1:0] ep;
    logic [31:0] ew;
    int fw;
    duty_a = '{2, 5, 1, 0, 4, 0, 0, 0};
    duty_b = duty_a;
    setup(1, 4);
    fw = first_wrap(1'b1, 4, 1);
    for (int j = 0; j < 40; j++) begin
      pq.push_back(model_pwm(j, 1'b1, 4, 1));
      exp_q.push_back({31'b0, j >= fw});
    end
    bus_write(A_CTRL, 32'h3);
    sel = 1'b1; we = 1'b0; addr = A_STAT;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      ep = pq.pop_front();
      ew = exp_q.pop_front();
      n_tests++;
      if (pwm_out !== ep) begin n_fail++; $display("FAIL center_pwm j=%0d got=%b exp=%b", j, pwm_out, ep); end
      n_tests++;
      if (rdata !== ew) begin n_fail++; $display("FAIL center_wrap j=%0d got=%h exp=%h", j, rdata, ew); end
    end
    sel = 1'b0;
  endtask

  task automatic test_extremes();
    logic [NCH-1:0] ep;
    duty_a = '{1, 0, 2, 65535, 0, 0, 0, 0};
    duty_b = duty_a;
    setup(2, 0);
    for (int j = 0; j < 15; j++) pq.push_back(model_pwm(j, 1'b0, 0, 2));
    bus_write(A_CTRL, 32'h1);
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      ep = pq.pop_front();
      n_tests++;
      if (pwm_out !== ep) begin n_fail++; $display("FAIL per0_pwm j=%0d got=%b exp=%b", j, pwm_out, ep); end
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    int waited;
    duty_a = '{2, 0, 0, 0, 0, 0, 0, 0};
    setup(0, 3);
    bus_write(A_CTRL, 32'h5);
    waited = 0;
    while (irq !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise got=%b exp=1 after %0d clks", irq, waited); end
    // Now just past boundary B; boundaries recur every 4 clks
    bus_write(A_STAT, 32'h1);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_w1c got=%b exp=0", irq); end
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = A_STAT; wdata = 32'h1;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_w1c_on_boundary got=%b exp=1", irq); end
    bus_read(8'(16 + 4 * NCH), d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL oob_read got=%h exp=0", d); end
  endtask

  task automatic test_disable_and_async_reset();
    logic [31:0] d;
    duty_a = '{10, 0, 0, 0, 0, 0, 0, 0};
    setup(0, 9);
    bus_write(A_CTRL, 32'h1);
    repeat (4) @(negedge clk);
    n_tests++;
    if (pwm_out[0] !== 1'b1) begin n_fail++; $display("FAIL dis_pre got=%b exp=1", pwm_out[0]); end
    bus_write(A_CTRL, 32'h0);
    @(negedge clk);
    n_tests++;
    if (pwm_out !== '0) begin n_fail++; $display("FAIL dis_post got=%b exp=0", pwm_out); end
    bus_write(A_CTRL, 32'h5);
    repeat (14) @(negedge clk);
    n_tests++;
    if (pwm_out[0] !== 1'b1 || irq !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre pwm=%b irq=%b exp 1/1", pwm_out[0], irq);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (pwm_out !== '0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL arst_now pwm=%b irq=%b exp 0/0", pwm_out, irq);
    end
    bus_read(A_PER, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL arst_period got=%h exp=0", d); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_regs();
    test_edge();
    test_double_buffer();
    test_center();
    test_extremes();
    test_irq();
    test_disable_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
